riscv_trace_encoder: RTL and testbench
======================================

// Module: riscv_trace_encoder
// PURPOSE
// - Producer side of the core's retire-trace stream: captures {pc, instruction, result} of each
//   retired RV32I instruction from top_riscv and emits it as framed 32-bit words on a
//   valid/ready stream toward a trace sink (bench monitor, UART bridge, debug port).
// - Decouples core retire rate from sink rate with a record FIFO; counts records lost to overflow.
// PARAMETERS
// - DEPTH      8      record FIFO depth, power of 2, >= 2
// - SYNC_BYTE  8'hA5  constant in header word bits [31:24]
// PORTS
// - clk            in   1    clock, rising edge
// - reset          in   1    asynchronous, active-high; all state cleared
// - trace_en       in   1    1 = capture retires; 0 = ignore retire_valid (not counted as drops)
// - trace_clear    in   1    sync flush: FIFO, drop count, seq, overflow
// - retire_valid   in   1    core retired one instruction this cycle
// - retire_pc      in   32   PC of retired instruction
// - retire_instr   in   32   instruction word
// - retire_result  in   32   value written back (core 'out')
// - trace_valid    out  1    trace_data holds a valid word
// - trace_ready    in   1    sink accepts word when trace_valid && trace_ready
// - trace_data     out  32   framed word
// - trace_last     out  1    high on final word (result) of a record
// - fifo_level     out  $clog2(DEPTH)+1  records queued (excl. the one being sent)
// - overflow       out  1    sticky: >=1 record dropped since reset/clear
// BEHAVIOUR
// - Reset: trace_valid=0, trace_data=0, trace_last=0, fifo_level=0, overflow=0, seq=0, drops=0, FSM=IDLE.
// - Push at clk edge when retire_valid && trace_en && !full (full: fifo_level==DEPTH, registered).
//   Entry = {SYNC_BYTE, seq[7:0], drops[15:0], pc, instr, result}; on push seq<=seq+1 (wraps 255->0),
//   drops<=0.
// - Drop: retire_valid && trace_en && full -> no push; drops<=drops+1 saturating at 16'hFFFF; overflow<=1.
// - Push vs pop in same cycle while full: push rejected (full evaluated before pop).
// - Frame, 4 words: W0 header {SYNC_BYTE, seq, drops_before_record}, W1 pc, W2 instr, W3 result.
// - FSM: IDLE, SEND(idx 0..3).
//   - IDLE & FIFO non-empty: pop head into output shadow register; next cycle SEND idx0, trace_valid=1.
//   - SEND: advance idx on valid&&ready; trace_data/trace_last stable while valid && !ready.
//   - idx3 accepted: FIFO non-empty -> pop same edge, next cycle SEND idx0 (no bubble);
//     else IDLE, trace_valid=0.
// - Latency: retire at cycle N into empty idle encoder -> header valid at cycle N+2.
//   Sustained throughput 1 record/4 cycles with trace_ready=1.
// - trace_clear: FIFO emptied, seq=0, drops=0, overflow=0 next cycle; a record already in SEND
//   completes all 4 words unchanged. Retire in the clear cycle is discarded, not counted.
// - Reset mid-record: trace_valid drops immediately (async); sink must resync on SYNC_BYTE.
// - trace_en=0 does not stop draining of queued records.
// STRUCTURE
// - riscv_trace_pkg: SYNC_BYTE default, TRACE_WORDS=4, record width 128, idx/state encodings,
//   header field offsets.
// - Sub-module trace_fifo: sync FIFO (WIDTH=128, DEPTH), push/pop/full/empty/level, async
//   reset, flush input.
// - Top: capture/drop logic, seq/drop counters, serializer FSM, output register.
// TESTING
// - Single retire pc=0x0, instr=0x002081B3, result=0x5, ready=1 -> at N+2 words A5000000,
//   00000000, 002081B3, 00000005; last on W3.
// - 3 back-to-back retires, ready=1 -> 12 contiguous valid words, seq 00,01,02, no bubble
//   between records.
// - ready=0 for 10 cycles mid-record (held at W1) -> trace_data/trace_last stable; resumes at
//   W2 when ready=1.
// - DEPTH=8, ready=0, 12 retires -> 1 record in shadow + 8 queued, 3 dropped, overflow=1,
//   fifo_level=8; next captured record header drops=0x0003.
// - trace_clear asserted while W1 of record seq=5 pending -> W1..W3 of that record still
//   sent; fifo_level=0, overflow=0; next record header seq=00.
// - reset asserted mid-W2 -> trace_valid=0 same cycle; after release first header has seq=00,
//   drops=0.

Source files
------------

// File: rtl/riscv_trace_encoder_pkg.sv
// Shared types and constants for the retire-trace encoder.
// Defines record layout, serializer state encoding and word selection.
package riscv_trace_encoder_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         TRACE_WORDS   = 4;
  localparam int         REC_W         = 32 * TRACE_WORDS;

  // Header word field offsets: {sync, seq, drops}
  localparam int HDR_SYNC_LSB  = 24;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_DROPS_LSB = 0;

  typedef logic [1:0] idx_t;
  localparam idx_t IDX_FIRST = 2'd0;
  localparam idx_t IDX_LAST  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic logic [31:0] make_header(input logic [7:0]  sync,
                                              input logic [7:0]  seq,
                                              input logic [15:0] drops);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_SYNC_LSB  +: 8]  = sync;
    hdr[HDR_SEQ_LSB   +: 8]  = seq;
    hdr[HDR_DROPS_LSB +: 16] = drops;
    return hdr;
  endfunction

  // Word 0 is the most significant slice of the record.
  function automatic logic [31:0] rec_word(input logic [REC_W-1:0] rec, input idx_t idx);
    logic [31:0] w;
    w = rec[31:0];
    case (idx)
      2'd0:    w = rec[127:96];
      2'd1:    w = rec[95:64];
      2'd2:    w = rec[63:32];
      default: w = rec[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/riscv_trace_encoder_if.sv
// Retire capture bus plus valid/ready trace word stream.
// master = encoder side, slave = core/sink side.
interface riscv_trace_encoder_if;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_instr;
  logic [31:0] retire_result;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_data;
  logic        trace_last;

  modport master (
    input  retire_valid, retire_pc, retire_instr, retire_result, trace_ready,
    output trace_valid, trace_data, trace_last
  );

  modport slave (
    output retire_valid, retire_pc, retire_instr, retire_result, trace_ready,
    input  trace_valid, trace_data, trace_last
  );
endinterface

// File: rtl/riscv_trace_encoder_fifo.sv
// Synchronous record FIFO with flush; full/empty/level derive from registered pointers.
module riscv_trace_encoder_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  assign level = r_wr_ptr - r_rd_ptr;
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/riscv_trace_encoder.sv
// Retire-trace producer: queues {pc, instr, result} records and serializes each
// as a 4-word frame (header, pc, instr, result) on a valid/ready stream.
module riscv_trace_encoder
  import riscv_trace_encoder_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic                     trace_clear,
  riscv_trace_encoder_if.master    bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  logic [7:0]       r_seq;
  logic [15:0]      r_drops;
  logic             r_overflow;
  state_t           r_state;
  state_t           w_state_nxt;
  idx_t             r_idx;
  idx_t             w_idx_nxt;
  logic [REC_W-1:0] r_shadow;
  logic [31:0]      r_data;
  logic             r_last;

  logic             w_capture;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_pop;
  logic [REC_W-1:0] w_entry;
  logic [REC_W-1:0] w_head;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Full is the registered level, so a same-cycle pop never frees room for a push.
  assign w_capture = bus.retire_valid && trace_en && !trace_clear;
  assign w_push    = w_capture && !w_full;
  assign w_drop    = w_capture && w_full;
  assign w_entry   = {make_header(SYNC_BYTE, r_seq, r_drops),
                      bus.retire_pc, bus.retire_instr, bus.retire_result};

  riscv_trace_encoder_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (trace_clear),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_entry),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seq      <= '0;
      r_drops    <= '0;
      r_overflow <= 1'b0;
    end else if (trace_clear) begin
      r_seq      <= '0;
      r_drops    <= '0;
      r_overflow <= 1'b0;
    end else if (w_push) begin
      r_seq   <= r_seq + 8'd1;
      r_drops <= '0;
    end else if (w_drop) begin
      r_drops    <= sat_inc16(r_drops);
      r_overflow <= 1'b1;
    end
  end

  assign w_accept = (r_state == ST_SEND) && bus.trace_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !trace_clear) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SEND;
          w_idx_nxt   = IDX_FIRST;
        end
      end
      ST_SEND: begin
        if (w_accept) begin
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = IDX_FIRST;
            if (!w_empty && !trace_clear) begin
              w_pop = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= IDX_FIRST;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Output stage: shadow holds the record in flight, data/last are the current word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_data   <= '0;
      r_last   <= 1'b0;
    end else if (w_pop) begin
      r_shadow <= w_head;
      r_data   <= rec_word(w_head, IDX_FIRST);
      r_last   <= 1'b0;
    end else if (w_accept && w_state_nxt == ST_SEND) begin
      r_data <= rec_word(r_shadow, w_idx_nxt);
      r_last <= (w_idx_nxt == IDX_LAST);
    end else if (w_state_nxt == ST_IDLE) begin
      r_data <= '0;
      r_last <= 1'b0;
    end
  end

  assign bus.trace_valid = (r_state == ST_SEND);
  assign bus.trace_data  = r_data;
  assign bus.trace_last  = r_last;
  assign overflow        = r_overflow;

endmodule

// File: tb/tb_riscv_trace_encoder.sv
// Bench for riscv_trace_encoder: table vectors, directed corner sequences and
// randomized traffic against a queue-based record model checked every cycle.
module tb_riscv_trace_encoder;

  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   trace_en = 1'b0;
  logic                   trace_clear = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;

  riscv_trace_encoder_if bus();

  riscv_trace_encoder #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .reset       (reset),
    .trace_en    (trace_en),
    .trace_clear (trace_clear),
    .bus         (bus),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending records plus the record being sent.
  logic [127:0] mq[$];
  logic         m_busy;
  int           m_idx;
  logic [127:0] m_sh;
  logic [7:0]   m_seq;
  logic [15:0]  m_drops;
  logic         m_ovf;

  task automatic model_reset();
    mq.delete();
    m_busy  = 1'b0;
    m_idx   = 0;
    m_sh    = '0;
    m_seq   = '0;
    m_drops = '0;
    m_ovf   = 1'b0;
  endtask

  function automatic logic [31:0] exp_word();
    logic [127:0] t;
    t = m_sh >> (32 * (3 - m_idx));
    return t[31:0];
  endfunction

  task automatic model_step();
    logic         full, acc, done, cap;
    logic [127:0] rec;
    if (reset) begin
      model_reset();
      return;
    end
    full = (mq.size() == DEPTH);
    acc  = m_busy && bus.trace_ready;
    done = acc && (m_idx == 3);
    cap  = bus.retire_valid && trace_en && !trace_clear;
    rec  = {8'hA5, m_seq, m_drops, bus.retire_pc, bus.retire_instr, bus.retire_result};
    if (acc && !done) m_idx++;
    if (!m_busy || done) begin
      if (mq.size() > 0 && !trace_clear) begin
        m_sh   = mq.pop_front();
        m_busy = 1'b1;
        m_idx  = 0;
      end else begin
        m_busy = 1'b0;
      end
    end
    if (trace_clear) begin
      mq.delete();
      m_seq   = '0;
      m_drops = '0;
      m_ovf   = 1'b0;
    end else if (cap) begin
      if (!full) begin
        mq.push_back(rec);
        m_seq   = m_seq + 8'd1;
        m_drops = '0;
      end else begin
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        m_ovf = 1'b1;
      end
    end
  endtask

  // One clock: compare against the model at negedge, advance the model at posedge.
  task automatic tick();
    @(negedge clk);
    if (reset) model_reset();
    chk("m_valid", 32'(bus.trace_valid), 32'(m_busy));
    if (m_busy) begin
      chk("m_data", bus.trace_data, exp_word());
      chk("m_last", 32'(bus.trace_last), 32'(m_idx == 3));
    end
    chk("m_level", 32'(fifo_level), 32'(mq.size()));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] res);
    bus.retire_valid  = 1'b1;
    bus.retire_pc     = pc;
    bus.retire_instr  = ins;
    bus.retire_result = res;
    tick();
    bus.retire_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.trace_ready = 1'b1;
    while ((bus.trace_valid || fifo_level != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(n < 200), 32'd1);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] res;
    logic [31:0] hdr;
  } vec_t;

  vec_t        tbl[4];
  logic        lv[$];
  logic [31:0] ld[$];

  initial begin
    logic [31:0] w[4];
    int s;

    model_reset();
    bus.retire_valid = 1'b0; bus.retire_pc = '0; bus.retire_instr = '0;
    bus.retire_result = '0; bus.trace_ready = 1'b1;
    trace_en = 1'b1;

    tbl[0] = '{32'h0000_0000, 32'h0020_81B3, 32'h0000_0005, 32'hA500_0000};
    tbl[1] = '{32'h0000_0004, 32'h0050_0093, 32'h0000_0005, 32'hA501_0000};
    tbl[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hA502_0000};
    tbl[3] = '{32'h0000_001C, 32'h4020_8033, 32'hFFFF_FFFE, 32'hA503_0000};

    tick(); tick();
    chk("rst_valid", 32'(bus.trace_valid), 32'd0);
    chk("rst_data", bus.trace_data, 32'd0);
    chk("rst_last", 32'(bus.trace_last), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick();

    // Isolated retires: header at N+2, then pc/instr/result, last on word 3
    for (int i = 0; i < 4; i++) begin
      retire(tbl[i].pc, tbl[i].ins, tbl[i].res);
      chk("tbl_n1_idle", 32'(bus.trace_valid), 32'd0);
      tick();
      w[0] = tbl[i].hdr; w[1] = tbl[i].pc; w[2] = tbl[i].ins; w[3] = tbl[i].res;
      for (int k = 0; k < 4; k++) begin
        chk("tbl_valid", 32'(bus.trace_valid), 32'd1);
        chk("tbl_word", bus.trace_data, w[k]);
        chk("tbl_last", 32'(bus.trace_last), 32'(k == 3));
        tick();
      end
      chk("tbl_end_idle", 32'(bus.trace_valid), 32'd0);
    end

    // Three back-to-back retires: 12 contiguous words, seq 04..06
    for (int i = 0; i < 3; i++) begin
      bus.retire_valid = 1'b1; bus.retire_pc = 32'h100 + 32'(i * 4);
      bus.retire_instr = 32'h13; bus.retire_result = 32'(i);
      tick();
      lv.push_back(bus.trace_valid); ld.push_back(bus.trace_data);
    end
    bus.retire_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      lv.push_back(bus.trace_valid); ld.push_back(bus.trace_data);
    end
    s = -1;
    for (int i = 0; i < lv.size(); i++) if (s < 0 && lv[i]) s = i;
    chk("b2b_start", 32'(s), 32'd1);
    if (s >= 0 && s + 12 <= lv.size()) begin
      for (int i = 0; i < 12; i++) chk("b2b_contig", 32'(lv[s + i]), 32'd1);
      chk("b2b_hdr0", ld[s],     32'hA504_0000);
      chk("b2b_hdr1", ld[s + 4], 32'hA505_0000);
      chk("b2b_hdr2", ld[s + 8], 32'hA506_0000);
      if (s + 12 < lv.size()) chk("b2b_after", 32'(lv[s + 12]), 32'd0);
    end

    // Stall 10 cycles while W1 is presented
    retire(32'h200, 32'h0000_0013, 32'h7);
    tick(); tick();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_data", bus.trace_data, 32'h200);
      chk("stall_last", 32'(bus.trace_last), 32'd0);
      tick();
    end
    chk("stall_hold", bus.trace_data, 32'h200);
    bus.trace_ready = 1'b1;
    tick();
    chk("stall_w2", bus.trace_data, 32'h13);
    tick();
    chk("stall_w3", bus.trace_data, 32'h7);
    chk("stall_w3_last", 32'(bus.trace_last), 32'd1);
    tick();

    // Overflow: 12 retires with sink stalled
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 12; i++) retire(32'h300 + 32'(i), 32'h33, 32'(i));
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain();
    retire(32'h400, 32'h44, 32'h4);
    tick();
    chk("ovf_next_hdr", bus.trace_data, 32'hA511_0003);
    drain();

    // Clear while W1 of record seq=5 pending
    trace_clear = 1'b1; tick(); trace_clear = 1'b0;
    chk("clr_ovf0", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) retire(32'h500 + 32'(i), 32'h50, 32'(i));
    drain();
    bus.trace_ready = 1'b0;
    retire(32'h505, 32'h555, 32'h5A5);
    retire(32'h506, 32'h666, 32'h6A6);
    retire(32'h507, 32'h777, 32'h7A7);
    chk("clr_hdr5", bus.trace_data, 32'hA505_0000);
    bus.trace_ready = 1'b1; tick(); bus.trace_ready = 1'b0;
    chk("clr_w1", bus.trace_data, 32'h505);
    trace_clear = 1'b1;
    bus.retire_valid = 1'b1; bus.retire_pc = 32'h999;
    tick();
    trace_clear = 1'b0; bus.retire_valid = 1'b0;
    chk("clr_level", 32'(fifo_level), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_w1_hold", bus.trace_data, 32'h505);
    bus.trace_ready = 1'b1;
    tick(); chk("clr_w2", bus.trace_data, 32'h555);
    tick(); chk("clr_w3", bus.trace_data, 32'h5A5);
    tick(); chk("clr_idle", 32'(bus.trace_valid), 32'd0);
    retire(32'h600, 32'h66, 32'h6);
    tick();
    chk("clr_next_hdr", bus.trace_data, 32'hA500_0000);
    drain();

    // Reset asserted during W2
    retire(32'h700, 32'h77, 32'h7);
    retire(32'h704, 32'h78, 32'h8);
    tick(); tick();
    chk("rstm_w2", bus.trace_data, 32'h77);
    reset = 1'b1;
    #1;
    chk("rstm_valid_now", 32'(bus.trace_valid), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    retire(32'h800, 32'h88, 32'h8);
    tick();
    chk("rstm_hdr", bus.trace_data, 32'hA500_0000);
    drain();

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      bus.retire_valid  = ($urandom_range(99) < 55);
      bus.retire_pc     = $urandom;
      bus.retire_instr  = $urandom;
      bus.retire_result = $urandom;
      trace_en          = ($urandom_range(99) < 90);
      bus.trace_ready   = ($urandom_range(99) < 60);
      trace_clear       = ($urandom_range(99) < 2);
      tick();
    end
    bus.retire_valid = 1'b0; trace_clear = 1'b0; trace_en = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
